input_conditioner: RTL and testbench

Parametrised multi-channel input conditioner for asynchronous board inputs such as paddle buttons and switches. It generalises the single reset-able D flip-flop into a per-channel chain:
- N-stage synchroniser;
- counter-based debouncer with an optional sample strobe;
- registered rise/fall edge pulses.

It sits between the top-level input pins and the game-control logic, so downstream FSMs see clean, single-cycle events.

---
 rtl/input_pkg.sv | 15 +
 rtl/input_channel.sv | 81 ++++++++
 rtl/input_conditioner.sv | 39 +++
 tb/tb_input_conditioner.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// Shared constants and helpers for the multi-channel input conditioner.
package input_pkg;

  localparam int SYNC_STAGES_MIN         = 2;
  localparam int SYNC_STAGES_MAX         = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  // Debounce counter width; bypass (0 cycles) still needs a 1-bit vector.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/input_channel.sv
// One conditioner channel: N-flop synchroniser, counter debouncer and
// registered rise/fall pulses aligned with the level update.
module input_channel
  import input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_nxt_s;
  logic                   level_r;
  logic                   level_nxt_s;
  logic                   rise_r;
  logic                   fall_r;
  logic                   sync_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser shift chain, free-running regardless of sample_en
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Debounce next-state: any match with the current level discards the count
  always_comb begin
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    if (DEBOUNCE_CYCLES == 0) begin
      cnt_nxt_s   = '0;
      level_nxt_s = sync_s;
    end else if (sync_s == level_r) begin
      cnt_nxt_s = '0;
    end else if (sample_en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_nxt_s   = '0;
        level_nxt_s = ~level_r;
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Level, counter and edge-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
      rise_r  <= level_nxt_s & ~level_r;
      fall_r  <= ~level_nxt_s & level_r;
    end
  end

  assign level_out = level_r;
  assign rise_out  = rise_r;
  assign fall_out  = fall_r;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: WIDTH independent copies of input_channel
// between asynchronous board pins and the game-control logic.
module input_conditioner
  import input_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out
);

  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
    $fatal(1, "input_conditioner: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    input_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .raw_in    (raw_in[i]),
      .level_out (level_out[i]),
      .rise_out  (rise_out[i]),
      .fall_out  (fall_out[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench: vector table for reset/press/glitch, hand sequences for
// strobed debounce, reset mid-count and bypass-mode simultaneity.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [3:0] raw_in, level_out, rise_out, fall_out;
  logic [3:0] raw_b, level_b, rise_b, fall_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       se;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl[$];

  input_conditioner dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .raw_in(raw_in),
    .level_out(level_out), .rise_out(rise_out), .fall_out(fall_out)
  );

  input_conditioner #(.DEBOUNCE_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .sample_en(sample_en), .raw_in(raw_b),
    .level_out(level_b), .rise_out(rise_b), .fall_out(fall_b)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic se, input logic [3:0] raw,
                              input logic [3:0] lvl, input logic [3:0] rise,
                              input logic [3:0] fall);
    vec_t v;
    v.rst = r; v.se = se; v.raw = raw; v.lvl = lvl; v.rise = rise; v.fall = fall;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b1; raw_in = 4'hF; raw_b = 4'h0;

    // reset with inputs high, then settle
    tbl.push_back(mk(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0));
    // clean press on ch0: level and rise on the 6th edge
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1'b0, 1'b1, 4'h1, 4'h1, 4'h1, 4'h0));
    tbl.push_back(mk(1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0));
    // 3-cycle glitch on ch1 must be rejected
    for (int k = 1; k <= 3; k++) tbl.push_back(mk(1'b0, 1'b1, 4'h3, 4'h1, 4'h0, 4'h0));
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; sample_en = tbl[i].se; raw_in = tbl[i].raw;
      tick();
      chk($sformatf("row%0d level", i), level_out, tbl[i].lvl);
      chk($sformatf("row%0d rise", i), rise_out, tbl[i].rise);
      chk($sformatf("row%0d fall", i), fall_out, tbl[i].fall);
      if (i == 1) chk("bypass reset level", level_b, 4'h0);
    end

    // strobed debounce on ch2: enabled on edges 3,5,7,9 only
    raw_in = 4'h5;
    for (int e = 1; e <= 9; e++) begin
      sample_en = (e >= 3 && (e % 2) == 1) ? 1'b1 : 1'b0;
      tick();
      chk($sformatf("strobe e%0d level", e), level_out, (e == 9) ? 4'h5 : 4'h1);
      chk($sformatf("strobe e%0d rise", e), rise_out, (e == 9) ? 4'h4 : 4'h0);
    end
    sample_en = 1'b1;
    tick();
    chk("strobe after rise", rise_out, 4'h0);

    // ch3 counts to 2, then a one-cycle reset drops everything
    raw_in = 4'hD;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("midcnt e%0d level", e), level_out, 4'h5);
    end
    rst = 1'b1;
    tick();
    chk("post-rst level", level_out, 4'h0);
    chk("post-rst rise", rise_out, 4'h0);
    chk("post-rst fall", fall_out, 4'h0);
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("rel e%0d level", e), level_out, (e == 6) ? 4'hD : 4'h0);
      chk($sformatf("rel e%0d rise", e), rise_out, (e == 6) ? 4'hD : 4'h0);
    end
    // release ch3: fall pulse 6 edges later
    raw_in = 4'h5;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("fall e%0d level", e), level_out, (e >= 6) ? 4'h5 : 4'hD);
      chk($sformatf("fall e%0d fall", e), fall_out, (e == 6) ? 4'h8 : 4'h0);
      chk($sformatf("fall e%0d rise", e), rise_out, 4'h0);
    end

    // bypass instance: sample_en ignored, simultaneous pulses after 3 edges
    sample_en = 1'b0;
    raw_b = 4'h5;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("byp e%0d level", e), level_b, (e >= 3) ? 4'h5 : 4'h0);
      chk($sformatf("byp e%0d rise", e), rise_b, (e == 3) ? 4'h5 : 4'h0);
      chk($sformatf("byp e%0d fall", e), fall_b, 4'h0);
    end
    raw_b = 4'h0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("bypf e%0d fall", e), fall_b, (e == 3) ? 4'h5 : 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
